// File: rtl/fprint_shm_log_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fprint_shm_log_writer                                         |
// | Summary  : Buffers fingerprint results and writes them to a circular log |
// |            in shared memory, followed by a software-polled header word.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fprint_shm_log_writer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LOG_BASE   = 8'h10,
    parameter int         LOG_SIZE   = 16,
    parameter logic [7:0] HEAD_ADDR  = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fp_valid,
    output logic        fp_ready,
    input  logic [31:0] fp_data,
    input  logic [3:0]  fp_task,
    output logic [7:0]  mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_chipselect,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic        mem_clken,
    output logic        wrapped,
    input  logic        clear_wrapped,
    output logic [15:0] entries_written
);

    localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_IW = (LOG_SIZE > 1) ? $clog2(LOG_SIZE) : 1;
    localparam logic [c_AW:0]   c_FULL_COUNT = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(LOG_SIZE - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WR_DATA = 2'd1;
    localparam logic [1:0] c_WR_HEAD = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_active;
    logic [35:0]     r_fifo [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [31:0]     r_ent_data;
    logic [3:0]      r_ent_task;
    logic [c_IW-1:0] r_idx;
    logic [15:0]     r_entries_written;
    logic            r_wrapped;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_head_done;
    logic            w_wrap_evt;
    logic [3:0]      w_idx4;
    logic [15:0]     w_seq_nxt;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign w_full    = (r_count == c_FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign fp_ready  = r_active & ~w_full;
    assign w_push    = fp_valid & fp_ready;
    assign mem_clken = r_active;

    assign w_seq_nxt       = r_entries_written + 16'd1;
    assign w_wrap_evt      = w_head_done && (r_idx == c_LAST_IDX);
    assign entries_written = r_entries_written;
    assign wrapped         = r_wrapped;

    generate
        if (c_IW >= 4) begin : g_idx_trunc
            assign w_idx4 = r_idx[3:0];
        end else begin : g_idx_ext
            assign w_idx4 = {{(4 - c_IW){1'b0}}, r_idx};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {fp_task, fp_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= c_IDLE;
            r_ent_data        <= '0;
            r_ent_task        <= '0;
            r_idx             <= '0;
            r_entries_written <= '0;
            r_wrapped         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                {r_ent_task, r_ent_data} <= r_fifo[r_rd_ptr];
            end
            if (w_head_done) begin
                r_idx             <= r_idx + 1'b1;
                r_entries_written <= w_seq_nxt;
            end
            // A wrap in the same cycle as a clear request keeps the flag set.
            if (w_wrap_evt) begin
                r_wrapped <= 1'b1;
            end else if (clear_wrapped) begin
                r_wrapped <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_head_done    = 1'b0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = 4'h0;
        mem_address    = 8'h00;
        mem_writedata  = 32'h0000_0000;
        case (r_state)
            c_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_WR_DATA;
                end
            end
            c_WR_DATA: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = 4'hF;
                mem_address    = LOG_BASE + 8'(r_idx);
                mem_writedata  = r_ent_data;
                w_state_nxt    = c_WR_HEAD;
            end
            c_WR_HEAD: begin
                mem_chipselect = 1'b1;
                mem_write      = 1'b1;
                mem_byteenable = 4'hF;
                mem_address    = HEAD_ADDR;
                mem_writedata  = {8'h00, r_ent_task, w_idx4, w_seq_nxt};
                w_head_done    = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_WR_DATA;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fprint_shm_log_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fprint_shm_log_writer                                      |
// | Summary  : Directed self-checking bench for fprint_shm_log_writer.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fprint_shm_log_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fp_valid = 1'b0;
    logic        fp_ready;
    logic [31:0] fp_data = '0;
    logic [3:0]  fp_task = '0;
    logic [7:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic        wrapped;
    logic        clear_wrapped = 1'b0;
    logic [15:0] entries_written;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] shadow [256];
    logic [7:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          log_cyc  [$];

    always #5 clk = ~clk;

    fprint_shm_log_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .fp_valid        (fp_valid),
        .fp_ready        (fp_ready),
        .fp_data         (fp_data),
        .fp_task         (fp_task),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .wrapped         (wrapped),
        .clear_wrapped   (clear_wrapped),
        .entries_written (entries_written)
    );

    // Shared-memory model: a write presented during a cycle lands at the next rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset_n && mem_chipselect && mem_write) begin
            shadow[mem_address] = mem_writedata;
            log_addr.push_back(mem_address);
            log_data.push_back(mem_writedata);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic push(input logic [3:0] t, input logic [31:0] d);
        int n = 0;
        fp_valid = 1'b1;
        fp_task  = t;
        fp_data  = d;
        while (!fp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 32'(fp_ready), 32'd1);
        @(negedge clk);
        fp_valid = 1'b0;
    endtask

    task automatic wait_entries(input int n, input string tag);
        int k = 0;
        while (entries_written != 16'(n) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(entries_written), 32'(n));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        fp_valid      = 1'b0;
        clear_wrapped = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int k;
        // Reset state
        #1;
        check("rst_ready",   32'(fp_ready),        32'd0);
        check("rst_clken",   32'(mem_clken),       32'd0);
        check("rst_cs",      32'(mem_chipselect),  32'd0);
        check("rst_write",   32'(mem_write),       32'd0);
        check("rst_addr",    32'(mem_address),     32'd0);
        check("rst_be",      32'(mem_byteenable),  32'd0);
        check("rst_wdata",   mem_writedata,        32'd0);
        check("rst_wrapped", 32'(wrapped),         32'd0);
        check("rst_entries", 32'(entries_written), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(fp_ready),  32'd1);
        check("post_rst_clken", 32'(mem_clken), 32'd1);

        // Single entry, cycle-exact latency
        fp_valid = 1'b1;
        fp_task  = 4'd3;
        fp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        fp_valid = 1'b0;
        check("e0_idle_write", 32'(mem_write), 32'd0);
        @(negedge clk);
        check("e1_data_cs",    32'(mem_chipselect), 32'd1);
        check("e1_data_write", 32'(mem_write),      32'd1);
        check("e1_data_be",    32'(mem_byteenable), 32'hF);
        check("e1_data_addr",  32'(mem_address),    32'h10);
        check("e1_data_wdata", mem_writedata,       32'hDEAD_BEEF);
        @(negedge clk);
        check("e2_head_addr",  32'(mem_address),    32'h00);
        check("e2_head_wdata", mem_writedata,       32'h0030_0001);
        check("e2_head_write", 32'(mem_write),      32'd1);
        @(negedge clk);
        check("e3_entries",    32'(entries_written), 32'd1);
        check("e3_idle_write", 32'(mem_write),       32'd0);

        // Back-to-back burst of six
        do_reset();
        clear_log();
        for (int i = 1; i <= 6; i++) push(4'(i), 32'(i));
        wait_entries(6, "burst_entries");
        check("burst_log_len", 32'(log_addr.size()), 32'd12);
        if (log_addr.size() == 12) begin
            for (int i = 0; i < 6; i++) begin
                check("burst_slot_addr", 32'(log_addr[2*i]),   32'(8'h10 + i));
                check("burst_slot_data", log_data[2*i],        32'(i + 1));
                check("burst_head_addr", 32'(log_addr[2*i+1]), 32'h00);
            end
            check("burst_no_gaps", 32'(log_cyc[11] - log_cyc[0]), 32'd11);
        end
        check("burst_slot15", shadow[8'h15], 32'd6);
        check("burst_header", shadow[8'h00], 32'h0065_0006);

        // Fill the FIFO: from idle, seven consecutive pushes leave four buffered
        for (int i = 7; i <= 13; i++) push(4'(i), 32'(i));
        check("full_ready_low", 32'(fp_ready), 32'd0);
        push(4'd14, 32'd14);
        wait_entries(14, "fill_entries");
        check("fill_slot1d", shadow[8'h1D], 32'd14);
        check("fill_header", shadow[8'h00], 32'h00ED_000E);

        // Wrap around the 16-slot log
        do_reset();
        for (int i = 1; i <= 15; i++) push(4'(i), 32'h100 + 32'(i));
        wait_entries(15, "wrap_e15");
        check("wrap_before", 32'(wrapped), 32'd0);
        push(4'hA, 32'h110);
        wait_entries(16, "wrap_e16");
        check("wrap_after16",  32'(wrapped),  32'd1);
        check("wrap_head16",   shadow[8'h00], 32'h00AF_0010);
        check("wrap_slot1f",   shadow[8'h1F], 32'h110);
        push(4'hB, 32'h111);
        wait_entries(17, "wrap_e17");
        check("wrap_slot10",   shadow[8'h10], 32'h111);
        check("wrap_head17",   shadow[8'h00], 32'h00B0_0011);
        check("wrap_sticky",   32'(wrapped),  32'd1);
        clear_wrapped = 1'b1;
        @(negedge clk);
        clear_wrapped = 1'b0;
        check("wrap_cleared",  32'(wrapped),  32'd0);

        // Clear request coincident with the wrapping header write
        do_reset();
        for (int i = 1; i <= 15; i++) push(4'(i), 32'(i));
        wait_entries(15, "simul_e15");
        push(4'hC, 32'h220);
        @(negedge clk);
        check("simul_wrdata_addr", 32'(mem_address), 32'h1F);
        @(negedge clk);
        check("simul_wrhead_addr", 32'(mem_address), 32'h00);
        clear_wrapped = 1'b1;
        @(negedge clk);
        clear_wrapped = 1'b0;
        check("simul_set_wins",  32'(wrapped), 32'd1);
        @(negedge clk);
        check("simul_set_holds", 32'(wrapped), 32'd1);

        // Reset asserted during a data write with another entry queued
        do_reset();
        push(4'd1, 32'h333);
        push(4'd2, 32'h444);
        check("mid_wrdata_write", 32'(mem_write),   32'd1);
        check("mid_wrdata_addr",  32'(mem_address), 32'h10);
        reset_n = 1'b0;
        #1;
        check("mid_rst_write", 32'(mem_write),      32'd0);
        check("mid_rst_cs",    32'(mem_chipselect), 32'd0);
        clear_log();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_ready",   32'(fp_ready),        32'd1);
        check("mid_entries", 32'(entries_written), 32'd0);
        repeat (6) @(negedge clk);
        check("mid_no_write",    32'(log_addr.size()),  32'd0);
        check("mid_entries_end", 32'(entries_written), 32'd0);

        // Sequence counter rollover
        force dut.r_entries_written = 16'hFFFF;
        @(negedge clk);
        release dut.r_entries_written;
        check("roll_preset", 32'(entries_written), 32'h0000_FFFF);
        push(4'd5, 32'hAA);
        k = 0;
        while (!(mem_write && mem_address == 8'h00) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("roll_header", mem_writedata, 32'h0050_0000);
        @(negedge clk);
        check("roll_entries", 32'(entries_written), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fprint_shm_log_writer.md
Name: fprint_shm_log_writer

Overview:
- Upstream feeder for the 256x32 single-port shared-memory RAM, which has byte enables, 1-cycle read latency, no waitrequest, and write = chipselect & write.
- Accepts fingerprint results from the comparator/CRC side over a valid/ready stream and buffers them in a small FIFO.
- Writes each result into a circular log region of shared memory, then updates a header word that software polls.
- Sole writer on its shared-memory port; no read path.

Parameters:
FIFO_DEPTH, 4, input FIFO entries; power of 2, minimum 2
LOG_BASE, 8'h10, word address of log slot 0
LOG_SIZE, 16, log slots; power of 2; LOG_BASE+LOG_SIZE <= 256
HEAD_ADDR, 8'h00, word address of header word; outside the log region

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fp_valid  in  1  fingerprint entry valid
fp_ready  out  1  block can accept an entry
fp_data  in  32  fingerprint value
fp_task  in  4  task ID that produced fp_data
mem_address  out  8  shared-memory word address
mem_byteenable  out  4  byte enables; always 4'hF during writes
mem_chipselect  out  1  shared-memory select
mem_write  out  1  write strobe
mem_writedata  out  32  write data
mem_clken  out  1  RAM clock enable
wrapped  out  1  sticky: log index has wrapped at least once
clear_wrapped  in  1  synchronous clear of wrapped
entries_written  out  16  completed entries, modulo 2^16

Behaviour:
- Reset (async, reset_n=0):
  - FIFO empty; state IDLE; log index 0; entries_written 0; wrapped 0.
  - All mem_* outputs 0 except mem_clken=0.
  - fp_ready=0 while in reset.
- After reset release: mem_clken=1 constantly.
- Input handshake:
  - Entry {fp_task, fp_data} is pushed on a rising edge with fp_valid & fp_ready.
  - fp_ready = !fifo_full, from registered state only; no combinational path from the pop.
  - fp_ready is 0 when the FIFO is full, even in a cycle where a pop occurs.
  - Producer must hold fp_valid and its data stable until accepted.
- FSM states: IDLE, WR_DATA, WR_HEAD.
  - IDLE: if FIFO non-empty, pop head into an entry register and go to WR_DATA; else stay.
  - WR_DATA (1 cycle), outputs:
    - mem_chipselect=1, mem_write=1, mem_byteenable=4'hF
    - mem_address = LOG_BASE + idx
    - mem_writedata = latched fp_data
    - Next state: WR_HEAD.
  - WR_HEAD (1 cycle), outputs:
    - mem_chipselect=1, mem_write=1, mem_byteenable=4'hF
    - mem_address = HEAD_ADDR
    - mem_writedata = {8'h00, latched task[3:0], idx[3:0] zero-extended to 4 bits, entries_written+1 [15:0]}
    - For LOG_SIZE>16, idx occupies bits [19:16] truncated; implementer keeps LOG_SIZE<=16 or widens by parameter.
  - On WR_HEAD exit (same edge):
    - idx <= (idx+1) mod LOG_SIZE
    - entries_written <= entries_written+1 (wraps 16'hFFFF -> 0)
    - If idx was LOG_SIZE-1, wrapped <= 1.
    - If FIFO non-empty, pop and go directly to WR_DATA; else go to IDLE.
- In IDLE, all mem_* outputs are 0 except mem_clken.
- Latency: entry accepted at edge E0 -> popped at E1 -> log word written at E2 -> header written at E3.
- Sustained throughput: 1 entry per 2 cycles. The FIFO absorbs bursts; once full, fp_ready drops.
- Simultaneous push and pop: both are allowed when not full; occupancy is unchanged.
- Ordering: the header is always written after its log word. Software reading a header sequence value N is guaranteed log slot data for entry N is present.
- clear_wrapped and a wrap event in the same cycle: set wins (wrapped=1).
- Reset mid-operation: any in-flight entry and all FIFO contents are discarded; a header write is never issued for an abandoned data write.
- mem_* outputs are decoded from registered state and entry registers only; no input-to-output combinational path.

Test Plan:
- Single entry: reset, then push fp_task=3, fp_data=32'hDEADBEEF.
  - Required: write 8'h10 <= 32'hDEADBEEF at E2.
  - Required: write 8'h00 <= 32'h0030_0001 at E3.
  - Required: entries_written=1, then IDLE with mem_write=0.
- Back-to-back burst: fp_valid held high for 6 entries (data 1..6).
  - Required: fp_ready drops once 4 entries are buffered.
  - Required: writes alternate data/header every cycle with no IDLE gaps.
  - Required: slots 8'h10..8'h15 hold 1..6; final header sequence field = 6.
- Wrap: push 17 entries.
  - Required: entry 17 is written to 8'h10.
  - Required: wrapped=1 after the 16th header write; header idx field 0 for entry 17.
  - Drive clear_wrapped -> wrapped=0 next cycle.
- Simultaneous clear/wrap: assert clear_wrapped in the cycle of the 16th WR_HEAD -> wrapped=1.
- Reset mid-operation: assert reset_n=0 during WR_DATA.
  - Required: mem_write=0 immediately; no header write; FIFO empty; entries_written=0.
  - Required: fp_ready=1 one cycle after release.
- Counter rollover: force entries_written=16'hFFFF, push one entry -> header low half 16'h0000, entries_written=0.
